signed_accum32: RTL

Streaming 32-bit signed accumulator that consumes one operand per handshake, adds it into a running sum and reports the final sum, carry-out and sticky overflow when the last operand of a packet arrives. It sits directly downstream of the 32-bit signed adders. The adder's (a, b) → (sum, cout, OF) contract is wrapped in a registered, flow-controlled stage so that multi-operand reductions can be fed from a stimulus or data source.

---
 rtl/signed_accum32.sv | 115 +++++++++++
 1 files changed

// File: rtl/signed_accum32.sv
// Streaming 32-bit signed accumulator: one operand per handshake, result held per packet.
// Optional SIGNED_ACCUM_SAT_EN clamps the running sum on signed overflow instead of wrapping.
module signed_accum32 #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic             out_cout,
  output logic             out_of,
  output logic [CNT_W-1:0] out_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               of_q, of_d;
  logic               cout_q, cout_d;

  logic               accept;
  logic               release_res;
  logic [32:0]        add_w;
  logic               ovf;

  assign accept      = in_valid && in_ready;
  assign release_res = out_valid && out_ready;

  assign add_w = {1'b0, acc_q} + {1'b0, in_data};
  assign ovf   = (acc_q[31] == in_data[31])
              && (add_w[31] != acc_q[31]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      of_q    <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      of_q    <= of_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          state_d = in_last ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q != HOLD);
    out_valid = (state_q == HOLD);
    out_sum   = acc_q;
    out_cout  = cout_q;
    out_of    = of_q;
    out_cnt   = cnt_q;
  end

  // Datapath next-state; cout always comes from the raw add.
  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    of_d   = of_q;
    cout_d = cout_q;
    if (release_res) begin
      acc_d  = '0;
      cnt_d  = '0;
      of_d   = 1'b0;
      cout_d = 1'b0;
    end else if (accept) begin
      cout_d = add_w[32];
      of_d   = of_q | ovf;
      cnt_d  = (cnt_q == {CNT_W{1'b1}})
             ? cnt_q : cnt_q + CNT_W'(1);
`ifdef SIGNED_ACCUM_SAT_EN
      if (ovf) begin
        acc_d = acc_q[31] ? 32'h8000_0000
                          : 32'h7FFF_FFFF;
      end else begin
        acc_d = add_w[31:0];
      end
`else
      acc_d = add_w[31:0];
`endif
    end
  end

endmodule
